modulo_varredura_matriz: RTL and testbench

- Parametrised successor of the per-row combinational preset generators.
- Drives N_DIGITS side-by-side 5x7 LED-matrix characters (digits 0-9) with time-multiplexed row scanning.
- Contains an internal 5x7 font, a row prescaler, a row counter and a frame-synchronous digit shadow register, so displayed digits never tear mid-frame.
- Sits between the clock/counter datapath (BCD digits) and the matrix pins.

---
 rtl/modulo_varredura_matriz.sv | 72 +++++++
 tb/tb_modulo_varredura_matriz.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/modulo_varredura_matriz.sv
// modulo_varredura_matriz: row-scanned driver for N_DIGITS side-by-side 5x7 LED digits with a frame-synchronous digit shadow.
module modulo_varredura_matriz #(
  parameter int N_DIGITS    = 2,
  parameter int DIV         = 4,
  parameter int ROW_ACT_LOW = 0,
  parameter int COL_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  output logic [6:0]            row_sel,
  output logic [5*N_DIGITS-1:0] cols,
  output logic                  frame_done
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic RL = ROW_ACT_LOW != 0;
  localparam logic CL = COL_ACT_LOW != 0;
  logic [PW-1:0]         r_pre_cnt;
  logic [2:0]            r_row_idx;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic                  r_load_pend;
  logic                  r_frame_done;
  logic                  w_adv;
  logic                  w_top;
  logic                  w_wrap;
  logic                  w_on;
  // The pending-load cycle only captures digits: pins stay off and the prescaler holds.
  assign w_adv  = en & ~r_load_pend;
  assign w_top  = r_pre_cnt == PW'(DIV - 1);
  assign w_wrap = w_adv & w_top & (r_row_idx == 3'd6);
  assign w_on   = en & ~rst & ~r_load_pend;
  function automatic logic [4:0] font_row(input logic [3:0] c, input logic [2:0] r);
    logic [34:0] g;
    case (c)
      4'd0:    g = {5'h0E, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h0E};
      4'd1:    g = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0C, 5'h04};
      4'd2:    g = {5'h1F, 5'h08, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'd3:    g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h02, 5'h1F};
      4'd4:    g = {5'h02, 5'h02, 5'h1F, 5'h12, 5'h0A, 5'h06, 5'h02};
      4'd5:    g = {5'h0E, 5'h11, 5'h01, 5'h01, 5'h1E, 5'h10, 5'h1F};
      4'd6:    g = {5'h0E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h08, 5'h06};
      4'd7:    g = {5'h08, 5'h08, 5'h08, 5'h04, 5'h02, 5'h01, 5'h1F};
      4'd8:    g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'd9:    g = {5'h0C, 5'h02, 5'h01, 5'h0F, 5'h11, 5'h11, 5'h0E};
      default: g = '0;
    endcase
    font_row = 5'(g >> (5 * r));
  endfunction
  assign row_sel    = (w_on ? 7'd1 << r_row_idx : 7'd0) ^ {7{RL}};
  assign frame_done = r_frame_done & en & ~rst;
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_col
    assign cols[5*k+:5] = (w_on ? font_row(r_shadow[4*k+:4], r_row_idx) : 5'd0) ^ {5{CL}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt    <= '0;
      r_row_idx    <= '0;
      r_shadow     <= '1;
      r_load_pend  <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_adv) begin
        r_pre_cnt <= w_top ? '0 : r_pre_cnt + PW'(1);
        if (w_top) r_row_idx <= r_row_idx == 3'd6 ? 3'd0 : r_row_idx + 3'd1;
      end
      if ((en & r_load_pend) | w_wrap) r_shadow <= digits;
      if (en) r_load_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// tb_modulo_varredura_matriz: directed and randomized checks of two scanner instances against a frame-level model.
module tb_modulo_varredura_matriz;
  logic clk = 1'b0;
  logic rst_a = 1'b1, en_a = 1'b0, rst_b = 1'b1, en_b = 1'b0;
  logic [7:0] dig_a = '0, dig_b = '0;
  logic [6:0] rs_a, rs_b;
  logic [9:0] co_a, co_b;
  logic fd_a, fd_b;
  int pass_n = 0, tot = 0;
  int row[2], pre[2], pend[2], mfd[2];
  int sh[2][2];
  int dv[2] = '{4, 1};
  int font[10][7] = '{
    '{'h0E, 'h11, 'h13, 'h15, 'h19, 'h11, 'h0E}, '{'h04, 'h0C, 'h04, 'h04, 'h04, 'h04, 'h0E},
    '{'h0E, 'h11, 'h01, 'h02, 'h04, 'h08, 'h1F}, '{'h1F, 'h02, 'h04, 'h02, 'h01, 'h11, 'h0E},
    '{'h02, 'h06, 'h0A, 'h12, 'h1F, 'h02, 'h02}, '{'h1F, 'h10, 'h1E, 'h01, 'h01, 'h11, 'h0E},
    '{'h06, 'h08, 'h10, 'h1E, 'h11, 'h11, 'h0E}, '{'h1F, 'h01, 'h02, 'h04, 'h08, 'h08, 'h08},
    '{'h0E, 'h11, 'h11, 'h0E, 'h11, 'h11, 'h0E}, '{'h0E, 'h11, 'h11, 'h0F, 'h01, 'h02, 'h0C}};

  modulo_varredura_matriz #(.N_DIGITS(2), .DIV(4), .ROW_ACT_LOW(0), .COL_ACT_LOW(0)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .digits(dig_a), .row_sel(rs_a), .cols(co_a), .frame_done(fd_a));
  modulo_varredura_matriz #(.N_DIGITS(2), .DIV(1), .ROW_ACT_LOW(1), .COL_ACT_LOW(1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .digits(dig_b), .row_sel(rs_b), .cols(co_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  function automatic void upd(int i, logic r, logic e, logic [7:0] d);
    if (r) begin
      row[i] = 0; pre[i] = 0; pend[i] = 1; mfd[i] = 0; sh[i][0] = 15; sh[i][1] = 15;
    end else begin
      mfd[i] = 0;
      if (e && pend[i] != 0) begin
        pend[i] = 0; sh[i][0] = int'(d[3:0]); sh[i][1] = int'(d[7:4]);
      end else if (e) begin
        pre[i]++;
        if (pre[i] == dv[i]) begin
          pre[i] = 0;
          row[i] = (row[i] + 1) % 7;
          if (row[i] == 0) begin
            mfd[i] = 1; sh[i][0] = int'(d[3:0]); sh[i][1] = int'(d[7:4]);
          end
        end
      end
    end
  endfunction

  function automatic logic [6:0] e_rs(int i, logic r, logic e);
    logic [6:0] v;
    v = (e && !r && pend[i] == 0) ? 7'(1 << row[i]) : 7'd0;
    return i == 1 ? ~v : v;
  endfunction

  function automatic logic [9:0] e_co(int i, logic r, logic e);
    logic [9:0] v;
    v = '0;
    for (int k = 0; k < 2; k++)
      if (e && !r && pend[i] == 0 && sh[i][k] < 10) v[5*k+:5] = 5'(font[sh[i][k]][row[i]]);
    return i == 1 ? ~v : v;
  endfunction

  task automatic step();
    @(posedge clk);
    upd(0, rst_a, en_a, dig_a);
    upd(1, rst_b, en_b, dig_b);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1; en_a = 1; en_b = 1; dig_a = 8'h10; dig_b = 8'h88;
    step();
    tot++; if (rs_a !== 7'h00) $display("FAIL rst_rows_a got %h exp 00", rs_a); else pass_n++;
    tot++; if (co_a !== 10'h000) $display("FAIL rst_cols_a got %h exp 000", co_a); else pass_n++;
    tot++; if (fd_a !== 1'b0) $display("FAIL rst_fd_a got %b exp 0", fd_a); else pass_n++;
    tot++; if (rs_b !== 7'h7F) $display("FAIL rst_rows_b got %h exp 7f", rs_b); else pass_n++;
    tot++; if (co_b !== 10'h3FF) $display("FAIL rst_cols_b got %h exp 3ff", co_b); else pass_n++;
    rst_a = 0; rst_b = 0;
    #1;
    tot++; if (rs_a !== 7'h00) $display("FAIL load_cyc_rows got %h exp 00", rs_a); else pass_n++;
    tot++; if (co_a !== 10'h000) $display("FAIL load_cyc_cols got %h exp 000", co_a); else pass_n++;
  endtask

  task automatic test_first_frame();
    step();
    for (int n = 0; n < 4; n++) begin
      tot++; if (rs_a !== 7'h01) $display("FAIL row0_sel cyc%0d got %h exp 01", n, rs_a); else pass_n++;
      tot++; if (co_a !== 10'h08E) $display("FAIL row0_cols cyc%0d got %h exp 08e", n, co_a); else pass_n++;
      step();
    end
    tot++; if (rs_a !== 7'h02) $display("FAIL row1_sel got %h exp 02", rs_a); else pass_n++;
    tot++; if (co_a !== 10'h191) $display("FAIL row1_cols got %h exp 191", co_a); else pass_n++;
  endtask

  task automatic test_frame_done();
    logic [6:0] prev;
    int cnt;
    prev = rs_a; cnt = 0;
    for (int n = 0; n < 56; n++) begin
      step();
      tot++; if (rs_a !== e_rs(0, rst_a, en_a)) $display("FAIL fd_rows got %h exp %h", rs_a, e_rs(0, rst_a, en_a)); else pass_n++;
      tot++; if (fd_a !== (prev == 7'h40 && rs_a == 7'h01)) $display("FAIL fd_pulse got %b exp %b", fd_a, prev == 7'h40 && rs_a == 7'h01); else pass_n++;
      cnt += int'(fd_a);
      prev = rs_a;
    end
    tot++; if (cnt != 2) $display("FAIL fd_count got %0d exp 2", cnt); else pass_n++;
  endtask

  task automatic test_tear();
    for (int n = 0; n < 40 && rs_a !== 7'h08; n++) step();
    tot++; if (rs_a !== 7'h08) $display("FAIL wait_row3 got %h exp 08", rs_a); else pass_n++;
    dig_a = 8'h27;
    for (int n = 0; n < 30 && rs_a !== 7'h01; n++) begin
      tot++; if (co_a !== {5'(font[1][row[0]]), 5'(font[0][row[0]])}) $display("FAIL tear row%0d got %h exp %h", row[0], co_a, {5'(font[1][row[0]]), 5'(font[0][row[0]])}); else pass_n++;
      step();
    end
    tot++; if (rs_a !== 7'h01) $display("FAIL wrap_row0 got %h exp 01", rs_a); else pass_n++;
    tot++; if (co_a !== 10'h1DF) $display("FAIL new_digits got %h exp 1df", co_a); else pass_n++;
  endtask

  task automatic test_invalid();
    dig_a = 8'hA5;
    step();
    for (int n = 0; n < 40 && fd_a !== 1'b1; n++) step();
    tot++; if (fd_a !== 1'b1) $display("FAIL wait_frame got %b exp 1", fd_a); else pass_n++;
    for (int n = 0; n < 28; n++) begin
      tot++; if (co_a[9:5] !== 5'h00) $display("FAIL invalid_blank got %h exp 00", co_a[9:5]); else pass_n++;
      if (rs_a == 7'h01) begin
        tot++; if (co_a[4:0] !== 5'h1F) $display("FAIL five_row0 got %h exp 1f", co_a[4:0]); else pass_n++;
      end
      if (rs_a == 7'h04) begin
        tot++; if (co_a[4:0] !== 5'h1E) $display("FAIL five_row2 got %h exp 1e", co_a[4:0]); else pass_n++;
      end
      step();
    end
  endtask

  task automatic test_en_freeze();
    for (int n = 0; n < 10 && rs_a === 7'h10; n++) step();
    for (int n = 0; n < 40 && rs_a !== 7'h10; n++) step();
    tot++; if (rs_a !== 7'h10) $display("FAIL wait_row4 got %h exp 10", rs_a); else pass_n++;
    step(); step();
    en_a = 0;
    #1;
    for (int n = 0; n < 10; n++) begin
      tot++; if (rs_a !== 7'h00 || co_a !== 10'h000 || fd_a !== 1'b0) $display("FAIL frozen got %h/%h/%b exp 00/000/0", rs_a, co_a, fd_a); else pass_n++;
      step();
    end
    en_a = 1;
    #1;
    tot++; if (rs_a !== 7'h10) $display("FAIL resume_a got %h exp 10", rs_a); else pass_n++;
    step();
    tot++; if (rs_a !== 7'h10) $display("FAIL resume_b got %h exp 10", rs_a); else pass_n++;
    step();
    tot++; if (rs_a !== 7'h20) $display("FAIL resume_row5 got %h exp 20", rs_a); else pass_n++;
  endtask

  task automatic test_act_low();
    for (int n = 0; n < 10 && rs_b !== 7'h7E; n++) step();
    for (int n = 0; n < 21; n++) begin
      tot++; if (rs_b !== ~(7'd1 << (n % 7))) $display("FAIL al_rows n%0d got %h exp %h", n, rs_b, ~(7'd1 << (n % 7))); else pass_n++;
      tot++; if (fd_b !== (n % 7 == 0)) $display("FAIL al_fd n%0d got %b exp %b", n, fd_b, n % 7 == 0); else pass_n++;
      if (n % 7 == 0) begin
        tot++; if (co_b !== ~10'h1CE) $display("FAIL al_cols got %h exp %h", co_b, ~10'h1CE); else pass_n++;
      end
      step();
    end
    for (int n = 0; n < 10 && rs_b !== 7'h77; n++) step();
    tot++; if (rs_b !== 7'h77) $display("FAIL wait_b_row3 got %h exp 77", rs_b); else pass_n++;
    rst_b = 1;
    step();
    tot++; if (rs_b !== 7'h7F || co_b !== 10'h3FF || fd_b !== 1'b0) $display("FAIL al_rst got %h/%h/%b exp 7f/3ff/0", rs_b, co_b, fd_b); else pass_n++;
    rst_b = 0;
    #1;
    tot++; if (rs_b !== 7'h7F) $display("FAIL al_load got %h exp 7f", rs_b); else pass_n++;
    step();
    tot++; if (rs_b !== 7'h7E || co_b !== ~10'h1CE) $display("FAIL al_restart got %h/%h exp 7e/%h", rs_b, co_b, ~10'h1CE); else pass_n++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst_a = $urandom % 64 == 0; en_a = $urandom % 8 != 0;
      rst_b = $urandom % 64 == 0; en_b = $urandom % 8 != 0;
      if ($urandom % 6 == 0) dig_a = 8'($urandom);
      if ($urandom % 6 == 0) dig_b = 8'($urandom);
      #1;
      tot++; if (rs_a !== e_rs(0, rst_a, en_a)) $display("FAIL rnd_rows_a got %h exp %h", rs_a, e_rs(0, rst_a, en_a)); else pass_n++;
      tot++; if (co_a !== e_co(0, rst_a, en_a)) $display("FAIL rnd_cols_a got %h exp %h", co_a, e_co(0, rst_a, en_a)); else pass_n++;
      tot++; if (fd_a !== (mfd[0] != 0 && en_a && !rst_a)) $display("FAIL rnd_fd_a got %b exp %b", fd_a, mfd[0] != 0 && en_a && !rst_a); else pass_n++;
      tot++; if (rs_b !== e_rs(1, rst_b, en_b)) $display("FAIL rnd_rows_b got %h exp %h", rs_b, e_rs(1, rst_b, en_b)); else pass_n++;
      tot++; if (co_b !== e_co(1, rst_b, en_b)) $display("FAIL rnd_cols_b got %h exp %h", co_b, e_co(1, rst_b, en_b)); else pass_n++;
      tot++; if (fd_b !== (mfd[1] != 0 && en_b && !rst_b)) $display("FAIL rnd_fd_b got %b exp %b", fd_b, mfd[1] != 0 && en_b && !rst_b); else pass_n++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_frame_done();
    test_tear();
    test_invalid();
    test_en_freeze();
    test_act_low();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
